dat_mem_stk: RTL and testbench

Parametrised successor to the single-port byte data memory. It keeps the combinational load port and clocked store port, and adds a hardware stack in the top STACK_DEPTH words of the array. The stack has push/pop, a stack pointer, full/empty status and sticky error flags. A post-reset clear sequencer zeroes the array before the CPU datapath may use it. It sits beside the register file and is driven by the controller's load/store/push/pop decode.

---
 rtl/dat_mem_stk.sv | 233 +++++++++++++++++++++++
 tb/tb_dat_mem_stk.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_stk.sv
// -----------------------------------------------------------------------------
// dat_mem_stk
//
// Purpose:
//   Byte-style data memory with a combinational load port and a clocked store
//   port. The top STACK_DEPTH words of the array double as a hardware stack
//   with push/pop, an occupancy pointer, full/empty status and sticky error
//   flags. After reset an optional sequencer zeroes the whole array before
//   the datapath may use it.
//
// Build option:
//   DAT_MEM_CLR_EN  - when defined, the post-reset clear sequencer is present
//                     and ready rises after 2**AW edges. When undefined,
//                     ready rises on the first edge after reset release and
//                     the array contents are undefined until written.
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   store enable, core[addr] <= dat_in
//   addr     in   load/store address (AW bits)
//   dat_in   in   store data and push data (DW bits)
//   dat_out  out  combinational core[addr]
//   push     in   push dat_in onto the stack
//   pop      in   pop the top of the stack
//   tos      out  combinational top-of-stack word, 0 when empty
//   sp       out  current stack occupancy
//   full     out  sp == STACK_DEPTH
//   empty    out  sp == 0
//   ovf      out  sticky, push while full
//   unf      out  sticky, pop while empty
//   coll     out  sticky, store dropped because of a concurrent push
//   err_clr  in   synchronous clear of ovf/unf/coll
//   ready    out  high once initialisation is complete
// -----------------------------------------------------------------------------
module dat_mem_stk #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [AW-1:0]                      addr,
  input  logic [DW-1:0]                      dat_in,
  output logic [DW-1:0]                      dat_out,
  input  logic                               push,
  input  logic                               pop,
  output logic [DW-1:0]                      tos,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               full,
  output logic                               empty,
  output logic                               ovf,
  output logic                               unf,
  output logic                               coll,
  input  logic                               err_clr,
  output logic                               ready
);

  localparam int DEPTH = 1 << AW;
  localparam int SPW   = $clog2(STACK_DEPTH + 1);

  // First word of the stack region; the stack grows upward from here.
  localparam logic [AW-1:0]  STK_BASE = AW'(DEPTH - STACK_DEPTH);
  localparam logic [SPW-1:0] SP_MAX   = SPW'(STACK_DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             coll_q, coll_d;

`ifdef DAT_MEM_CLR_EN
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
`endif

  logic [DW-1:0]    core [DEPTH];

  // Single write port, shared by the clear sweep, the stack and the store.
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [DW-1:0]    mem_wdata;

  logic [AW-1:0]    push_addr;
  logic [AW-1:0]    top_addr;
  logic             is_full;
  logic             is_empty;

  // The stack region never reaches the end of the address space when full
  // is low, so these AW-bit sums cannot wrap while they are in use.
  assign push_addr = STK_BASE + AW'(sp_q);
  assign top_addr  = push_addr - AW'(1);
  assign is_full   = (sp_q == SP_MAX);
  assign is_empty  = (sp_q == '0);

  // State, stack pointer and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      coll_q  <= coll_d;
    end
  end

`ifdef DAT_MEM_CLR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr_q <= '0;
    end else begin
      clr_ptr_q <= clr_ptr_d;
    end
  end
`endif

  // Next-state, stack and write-port arbitration. The stack write always
  // wins the port; a store that coincides with a push is dropped and
  // recorded in coll. Errors raised this cycle override err_clr.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    coll_d    = coll_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = dat_in;
`ifdef DAT_MEM_CLR_EN
    clr_ptr_d = clr_ptr_q;
`endif

    case (state_q)
      ST_INIT: begin
`ifdef DAT_MEM_CLR_EN
        // Sweep the array with zeros, one word per edge.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == {AW{1'b1}}) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_RUN;
`endif
      end

      ST_RUN: begin
        if (err_clr) begin
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          coll_d = 1'b0;
        end

        if (push && !pop) begin
          if (!is_full) begin
            mem_we    = 1'b1;
            mem_waddr = push_addr;
            sp_d      = sp_q + SPW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (pop && !push) begin
          if (!is_empty) begin
            sp_d = sp_q - SPW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end else if (push && pop) begin
          // Replace the top word in place; occupancy does not change.
          if (!is_empty) begin
            mem_we    = 1'b1;
            mem_waddr = top_addr;
          end else begin
            unf_d = 1'b1;
          end
        end

        if (wr_en) begin
          if (push) begin
            coll_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = dat_in;
          end
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Array storage. Contents are never reset; a write is suppressed while
  // rst_n is low so that an interrupted operation leaves no trace.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      core[mem_waddr] <= mem_wdata;
    end
  end

  // Occupancy can never pass the stack size.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (sp_q <= SP_MAX);
    end
  end

  assign dat_out = core[addr];
  assign tos     = is_empty ? '0 : core[top_addr];
  assign sp      = sp_q;
  assign full    = is_full;
  assign empty   = is_empty;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign coll    = coll_q;
  assign ready   = (state_q == ST_RUN);

endmodule

// File: tb/tb_dat_mem_stk.sv
// -----------------------------------------------------------------------------
// tb_dat_mem_stk
//
// Self-checking bench for dat_mem_stk with default parameters. A table of
// directed vectors covers store, push/pop, replace, collision and underflow;
// hand-written sequences cover reset/initialisation, overflow and an
// asynchronous reset in the middle of a run; a randomized phase is checked
// against a memory/stack model kept in the bench. Works with or without
// DAT_MEM_CLR_EN defined.
// -----------------------------------------------------------------------------
module tb_dat_mem_stk;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int SD   = 16;
  localparam int BASE = 256 - SD;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en, push, pop, err_clr;
  logic [7:0]   addr, dat_in;
  logic [7:0]   dat_out, tos;
  logic [4:0]   sp;
  logic         full, empty, ovf, unf, coll, ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain array memory, integer occupancy, flag bits.
  logic [7:0] mMem [256];
  bit         mValid [256];
  int         mSp;
  bit         mOvf, mUnf, mColl;

  typedef struct {
    bit       w;
    bit [7:0] a;
    bit [7:0] d;
    bit       pu;
    bit       po;
    bit       ec;
    bit [7:0] chkAddr;
    bit [7:0] expDout;
    int       expSp;
    bit [7:0] expTos;
    bit       expOvf;
    bit       expUnf;
    bit       expColl;
  } vec_t;

  vec_t vecs [$];

  dat_mem_stk #(.DW(DW), .AW(AW), .STACK_DEPTH(SD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .addr    (addr),
    .dat_in  (dat_in),
    .dat_out (dat_out),
    .push    (push),
    .pop     (pop),
    .tos     (tos),
    .sp      (sp),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .unf     (unf),
    .coll    (coll),
    .err_clr (err_clr),
    .ready   (ready)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic modelReset(input bit cleared);
    mSp   = 0;
    mOvf  = 1'b0;
    mUnf  = 1'b0;
    mColl = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mMem[i]   = 8'h00;
      mValid[i] = cleared;
    end
  endtask

  // One clock edge of the stack/memory rules, applied in priority order.
  task automatic modelStep(input bit w, input bit [7:0] a, input bit [7:0] d,
                           input bit pu, input bit po, input bit ec);
    if (ec) begin
      mOvf  = 1'b0;
      mUnf  = 1'b0;
      mColl = 1'b0;
    end
    if (pu && !po) begin
      if (mSp < SD) begin
        mMem[BASE + mSp]   = d;
        mValid[BASE + mSp] = 1'b1;
        mSp++;
      end else begin
        mOvf = 1'b1;
      end
    end else if (po && !pu) begin
      if (mSp > 0) mSp--;
      else mUnf = 1'b1;
    end else if (pu && po) begin
      if (mSp > 0) begin
        mMem[BASE + mSp - 1]   = d;
        mValid[BASE + mSp - 1] = 1'b1;
      end else begin
        mUnf = 1'b1;
      end
    end
    if (w) begin
      if (pu) mColl = 1'b1;
      else begin
        mMem[a]   = d;
        mValid[a] = 1'b1;
      end
    end
  endtask

  // Drive one operation across a rising edge, then return controls to idle.
  task automatic doOp(input bit w, input bit [7:0] a, input bit [7:0] d,
                      input bit pu, input bit po, input bit ec);
    wr_en   = w;
    addr    = a;
    dat_in  = d;
    push    = pu;
    pop     = po;
    err_clr = ec;
    @(posedge clk);
    modelStep(w, a, d, pu, po, ec);
    #1;
    idle();
  endtask

  task automatic applyStimulus(input vec_t v);
    doOp(v.w, v.a, v.d, v.pu, v.po, v.ec);
    addr = v.chkAddr;
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("vec%0d.sp", idx),    sp,      v.expSp);
    check($sformatf("vec%0d.full", idx),  full,    v.expSp == SD);
    check($sformatf("vec%0d.empty", idx), empty,   v.expSp == 0);
    check($sformatf("vec%0d.tos", idx),   tos,     v.expTos);
    check($sformatf("vec%0d.ovf", idx),   ovf,     v.expOvf);
    check($sformatf("vec%0d.unf", idx),   unf,     v.expUnf);
    check($sformatf("vec%0d.coll", idx),  coll,    v.expColl);
    check($sformatf("vec%0d.dout", idx),  dat_out, v.expDout);
  endtask

  // Compare every observable output with the model at the current addr.
  task automatic checkModel(input string tag);
    check({tag, ".sp"},    sp,    mSp);
    check({tag, ".full"},  full,  mSp == SD);
    check({tag, ".empty"}, empty, mSp == 0);
    check({tag, ".ovf"},   ovf,   mOvf);
    check({tag, ".unf"},   unf,   mUnf);
    check({tag, ".coll"},  coll,  mColl);
    if (mSp == 0) check({tag, ".tos"}, tos, 8'h00);
    else if (mValid[BASE + mSp - 1]) check({tag, ".tos"}, tos, mMem[BASE + mSp - 1]);
    if (mValid[addr]) check({tag, ".dout"}, dat_out, mMem[addr]);
  endtask

  initial begin
    int cnt;
    rst_n  = 1'b0;
    addr   = 8'h00;
    dat_in = 8'h00;
    idle();
    modelReset(1'b0);

    // Reset values while rst_n is held low.
    #3;
    check("rst.ready", ready, 1'b0);
    check("rst.sp",    sp,    5'd0);
    check("rst.empty", empty, 1'b1);
    check("rst.full",  full,  1'b0);
    check("rst.flags", {ovf, unf, coll}, 3'b000);

    // Release reset and hold a push during initialisation; it must be ignored.
    @(negedge clk);
    rst_n  = 1'b1;
    push   = 1'b1;
    dat_in = 8'h77;
`ifdef DAT_MEM_CLR_EN
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      if (i == 1)   check("init.ready_edge1",   ready, 1'b0);
      if (i == 255) check("init.ready_edge255", ready, 1'b0);
    end
    check("init.ready_edge256", ready, 1'b1);
    idle();
    modelReset(1'b1);
    addr = 8'h37;
    #1;
    check("init.dout_37", dat_out, 8'h00);
    addr = 8'h11;
    #1;
    check("init.dout_11", dat_out, 8'h00);
`else
    @(posedge clk);
    #1;
    check("init.ready_edge1", ready, 1'b1);
    idle();
    modelReset(1'b0);
`endif
    check("init.sp_ignored_push", sp, 5'd0);

    // Directed vectors: store, push/pop, replace, collision, underflow.
    //           w  a      d      pu po ec chk    dout   sp tos    ovf unf coll
    vecs.push_back('{1, 8'h10, 8'hA5, 0, 0, 0, 8'h10, 8'hA5, 0, 8'h00, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h11, 1, 0, 0, 8'hF0, 8'h11, 1, 8'h11, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h22, 1, 0, 0, 8'hF1, 8'h22, 2, 8'h22, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h33, 1, 0, 0, 8'hF2, 8'h33, 3, 8'h33, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h00, 0, 1, 0, 8'h10, 8'hA5, 2, 8'h22, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h7E, 1, 1, 0, 8'hF1, 8'h7E, 2, 8'h7E, 0, 0, 0});
    vecs.push_back('{1, 8'h20, 8'h5C, 0, 0, 0, 8'h20, 8'h5C, 2, 8'h7E, 0, 0, 0});
    vecs.push_back('{1, 8'h20, 8'h99, 1, 0, 0, 8'h20, 8'h5C, 3, 8'h99, 0, 0, 1});
    vecs.push_back('{0, 8'h00, 8'h00, 0, 0, 1, 8'hF2, 8'h99, 3, 8'h99, 0, 0, 0});
    vecs.push_back('{1, 8'h30, 8'h66, 0, 1, 0, 8'h30, 8'h66, 2, 8'h7E, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h00, 0, 1, 0, 8'hF0, 8'h11, 1, 8'h11, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h00, 0, 1, 0, 8'h30, 8'h66, 0, 8'h00, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h00, 0, 1, 0, 8'h10, 8'hA5, 0, 8'h00, 0, 1, 0});
    vecs.push_back('{0, 8'h00, 8'h00, 0, 1, 1, 8'h10, 8'hA5, 0, 8'h00, 0, 1, 0});
    vecs.push_back('{0, 8'h00, 8'h00, 0, 0, 1, 8'h10, 8'hA5, 0, 8'h00, 0, 0, 0});
    vecs.push_back('{0, 8'h00, 8'h55, 1, 1, 0, 8'hF0, 8'h11, 0, 8'h00, 0, 1, 0});
    vecs.push_back('{0, 8'h00, 8'h00, 0, 0, 1, 8'hF0, 8'h11, 0, 8'h00, 0, 0, 0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Fill to full, then overflow; the top word must survive the extra push.
    for (int i = 0; i < SD; i++) doOp(1'b0, 8'h00, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
    check("fill.full", full, 1'b1);
    check("fill.sp",   sp,   5'd16);
    doOp(1'b0, 8'h00, 8'hEE, 1'b1, 1'b0, 1'b0);
    addr = 8'hFF;
    #1;
    check("ovf.sp",      sp,      5'd16);
    check("ovf.flag",    ovf,     1'b1);
    check("ovf.core_ff", dat_out, 8'h8F);
    check("ovf.tos",     tos,     8'h8F);
    doOp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf.cleared", ovf, 1'b0);
    checkModel("post_ovf");

    // Randomized operations against the model; first half leans to pushes.
    for (int n = 0; n < 400; n++) begin
      bit       w, pu, po, ec;
      bit [7:0] a, d, ra;
      w  = ($urandom_range(0, 3) == 0);
      pu = (n < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
      po = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      ec = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 1) == 0) ? 8'(BASE + $urandom_range(0, SD - 1))
                                       : 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      ra = ($urandom_range(0, 1) == 0) ? 8'(BASE + $urandom_range(0, SD - 1)) : a;
      doOp(w, a, d, pu, po, ec);
      addr = ra;
      #1;
      checkModel($sformatf("rnd%0d", n));
    end

    // Build sp=5 with ovf set, then reset asynchronously between edges.
    for (int i = 0; i < SD; i++) doOp(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    doOp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= SD; i++) doOp(1'b0, 8'h00, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) doOp(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    addr = 8'hF4;
    #1;
    check("pre_rst.sp",   sp,      5'd5);
    check("pre_rst.ovf",  ovf,     1'b1);
    check("pre_rst.f4",   dat_out, 8'hC4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.sp",    sp,    5'd0);
    check("async_rst.ovf",   ovf,   1'b0);
    check("async_rst.ready", ready, 1'b0);
    check("async_rst.empty", empty, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!ready && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("rerun.ready", ready, 1'b1);
`ifdef DAT_MEM_CLR_EN
    check("rerun.edges", cnt, 256);
    addr = 8'hF4;
    #1;
    check("rerun.core_f4", dat_out, 8'h00);
`else
    check("rerun.edges", cnt, 1);
`endif
    check("rerun.sp",  sp,  5'd0);
    check("rerun.tos", tos, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
